// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam int unsigned PC_STEP   = 2;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {instr, pc} entries; flush overrides push and pop.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && !flush && push) mem[wr_ptr] <= push_data;
    end

    // Credit-based issue in the parent guarantees these never fire.
    always_ff @(posedge clock) begin
        if (reset_n && !flush) begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one-cycle-latency memory reads and
// buffers returned words for decode; stops after the halt word.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 16,
    parameter int unsigned      DATA_W   = 16,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = DATA_W + ADDR_W;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;
    logic              inflight, inflight_next;
    logic [ADDR_W-1:0] inflight_pc, inflight_pc_next;

    logic [CW-1:0]     q_count;
    logic [EW-1:0]     q_head;
    logic              pop, enq, halt_resp, issue;
    logic [CW:0]       occupancy;

    fetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (redirect),
        .push      (enq),
        .push_data ({imem_rdata, inflight_pc}),
        .pop       (pop),
        .count     (q_count),
        .head      (q_head)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            inflight    <= inflight_next;
            inflight_pc <= inflight_pc_next;
        end
    end

    always_comb begin
        ir_valid  = reset_n && (q_count != '0);
        pop       = ir_valid && ir_ready && !redirect;
        enq       = reset_n && inflight && !redirect;
        halt_resp = enq && (imem_rdata == DATA_W'(HALT_WORD));
        occupancy = (CW+1)'(q_count) + (CW+1)'(inflight) - (CW+1)'(pop);
        // A halt word arriving this cycle already blocks the next request.
        issue     = reset_n && (state == RUN) && !redirect && !halt_resp
                    && (occupancy < (CW+1)'(DEPTH));

        imem_req  = issue;
        imem_addr = fetch_pc;
        ir        = reset_n ? q_head[EW-1:ADDR_W] : '0;
        ir_pc     = reset_n ? q_head[ADDR_W-1:0]  : '0;
        halted    = reset_n && (state == HALT) && !inflight;

        state_next       = state;
        fetch_pc_next    = fetch_pc;
        inflight_next    = issue;
        inflight_pc_next = issue ? fetch_pc : inflight_pc;

        if (redirect) begin
            state_next    = RUN;
            fetch_pc_next = redirect_pc & ~ADDR_W'(1);
        end else begin
            if (issue)     fetch_pc_next = fetch_pc + ADDR_W'(PC_STEP);
            if (halt_resp) state_next    = HALT;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a request-driven scoreboard.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int NONE = -1;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    instr_fetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] halt_addr;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return (a == halt_addr) ? 16'hFFFF : (a ^ 16'h1234);
    endfunction

    initial imem_rdata = '0;
    always @(posedge clock) imem_rdata <= word_at(imem_addr);

    int n_assert = 0;
    int n_fail   = 0;

    fetch_entry_t sb[$];

    int          cyc;
    int          n_req, n_pop, last_req_cyc, first_pop_cyc, last_pop_cyc, first_halt_cyc;
    logic [15:0] last_req_addr;
    logic        s_req, s_valid, s_halted;
    logic [15:0] s_addr, s_ir, s_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_req = 0; n_pop = 0; last_req_cyc = NONE; last_req_addr = '0;
        first_pop_cyc = NONE; last_pop_cyc = NONE; first_halt_cyc = NONE;
    endtask

    task automatic tick();
        fetch_entry_t e;
        @(negedge clock);
        s_req = imem_req; s_addr = imem_addr; s_valid = ir_valid;
        s_ir = ir; s_pc = ir_pc; s_halted = halted;
        if (s_req) begin
            n_req++; last_req_cyc = cyc; last_req_addr = s_addr;
        end
        if (s_halted && first_halt_cyc == NONE) first_halt_cyc = cyc;
        if (!reset_n || redirect) begin
            sb.delete();
        end else if (s_valid && ir_ready) begin
            n_pop++;
            if (first_pop_cyc == NONE) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            chk("pop_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_ir", 32'(s_ir), 32'(e.instr));
                chk("sb_ir_pc", 32'(s_pc), 32'(e.pc));
            end
        end
        if (s_req && reset_n) sb.push_back('{instr: word_at(s_addr), pc: s_addr});
        cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        halt_addr = 16'd18; cyc = 0;
        clear_stats();
        repeat (3) tick();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_halted", 32'(s_halted), 32'd0);
        chk("rst_ir", 32'(s_ir), 32'd0);
        chk("rst_ir_pc", 32'(s_pc), 32'd0);

        // Straight-line run ending in the halt word at address 18
        reset_n = 1'b1; ir_ready = 1'b1; cyc = 0; clear_stats();
        tick();
        chk("c0_req", 32'(s_req), 32'd1);
        chk("c0_addr", 32'(s_addr), 32'h0000);
        chk("c0_valid", 32'(s_valid), 32'd0);
        tick();
        chk("c1_addr", 32'(s_addr), 32'h0002);
        chk("c1_valid", 32'(s_valid), 32'd0);
        tick();
        chk("c2_valid", 32'(s_valid), 32'd1);
        chk("c2_ir_pc", 32'(s_pc), 32'h0000);
        repeat (12) tick();
        chk("run_nreq", 32'(n_req), 32'd10);
        chk("run_last_addr", 32'(last_req_addr), 32'd18);
        chk("run_last_req_cyc", 32'(last_req_cyc), 32'd9);
        chk("run_npop", 32'(n_pop), 32'd10);
        chk("run_first_pop", 32'(first_pop_cyc), 32'd2);
        chk("run_last_pop", 32'(last_pop_cyc), 32'd11);
        chk("run_halt_cyc", 32'(first_halt_cyc), 32'd11);

        // Redirect out of HALT, coincident with ir_ready
        halt_addr = 16'h0001;
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        chk("hr_halted_hold", 32'(s_halted), 32'd1);
        chk("hr_no_req", 32'(s_req), 32'd0);
        redirect = 1'b0;
        tick();
        chk("hr_halted_drop", 32'(s_halted), 32'd0);
        chk("hr_req", 32'(s_req), 32'd1);
        chk("hr_addr", 32'(s_addr), 32'h0010);
        tick();
        chk("hr_r2_valid", 32'(s_valid), 32'd0);
        tick();
        chk("hr_r3_valid", 32'(s_valid), 32'd1);
        chk("hr_r3_pc", 32'(s_pc), 32'h0010);

        // Decode stalled from cycle 0
        reset_n = 1'b0; ir_ready = 1'b0;
        tick();
        reset_n = 1'b1; cyc = 0; clear_stats();
        repeat (6) tick();
        chk("stall_nreq", 32'(n_req), 32'd2);
        chk("stall_last_addr", 32'(last_req_addr), 32'h0002);
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_ir", 32'(s_ir), 32'(word_at(16'h0000)));
        chk("stall_ir_pc", 32'(s_pc), 32'h0000);
        chk("stall_sb", 32'(sb.size()), 32'd2);
        ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("release_valid", 32'(s_valid), 32'd1);
            chk("release_pc", 32'(s_pc), 32'(2 * i));
        end

        // Redirect with a queued word and a response inflight
        reset_n = 1'b0; ir_ready = 1'b0;
        tick();
        reset_n = 1'b1; cyc = 0;
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 16'h0041; ir_ready = 1'b1;
        tick();
        chk("rd_no_req", 32'(s_req), 32'd0);
        chk("rd_head_present", 32'(s_valid), 32'd1);
        redirect = 1'b0;
        tick();
        chk("rd_r1_req", 32'(s_req), 32'd1);
        chk("rd_r1_addr", 32'(s_addr), 32'h0040);
        chk("rd_r1_valid", 32'(s_valid), 32'd0);
        tick();
        chk("rd_r2_valid", 32'(s_valid), 32'd0);
        tick();
        chk("rd_r3_valid", 32'(s_valid), 32'd1);
        chk("rd_r3_pc", 32'(s_pc), 32'h0040);
        tick();
        chk("rd_r4_pc", 32'(s_pc), 32'h0042);

        // PC wrap past the top of the address space
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        chk("wrap_addr0", 32'(s_addr), 32'hFFFE);
        tick();
        chk("wrap_addr1", 32'(s_addr), 32'h0000);
        tick();
        chk("wrap_pc0", 32'(s_pc), 32'hFFFE);
        tick();
        chk("wrap_pc1", 32'(s_pc), 32'h0000);

        // One-cycle reset in the middle of streaming
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_req", 32'(s_req), 32'd0);
        chk("mrst_valid", 32'(s_valid), 32'd0);
        chk("mrst_halted", 32'(s_halted), 32'd0);
        chk("mrst_ir", 32'(s_ir), 32'd0);
        chk("mrst_ir_pc", 32'(s_pc), 32'd0);
        reset_n = 1'b1; cyc = 0;
        tick();
        chk("mrst_c0_req", 32'(s_req), 32'd1);
        chk("mrst_c0_addr", 32'(s_addr), 32'h0000);
        chk("mrst_c0_valid", 32'(s_valid), 32'd0);
        tick();
        chk("mrst_c1_valid", 32'(s_valid), 32'd0);
        tick();
        chk("mrst_c2_valid", 32'(s_valid), 32'd1);
        chk("mrst_c2_pc", 32'(s_pc), 32'h0000);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
